// File: rtl/bidir_pkg.sv
// Shared encodings for the half-duplex pin controller and its buffer tests.
// The direction constants match the bidirectional_buffer enable sense.
package bidir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TX   = 2'd1,
        ST_RX   = 2'd2,
        ST_TURN = 2'd3
    } state_e;

    localparam logic DIR_TX = 1'b1;
    localparam logic DIR_RX = 1'b0;

endpackage

// File: rtl/bidir_bus_ctrl.sv
// Ownership controller for a half-duplex pin: drives bus_oe/bus_out, samples bus_in,
// and inserts a released-bus turnaround after every drive or receive burst.
module bidir_bus_ctrl
    import bidir_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int TURN_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_valid,
    input  logic [WIDTH-1:0] tx_data,
    output logic             tx_ready,
    input  logic             rx_req,
    output logic             rx_valid,
    output logic [WIDTH-1:0] rx_data,
    output logic             bus_oe,
    output logic [WIDTH-1:0] bus_out,
    input  logic [WIDTH-1:0] bus_in,
    output logic             busy
);

    localparam int                CNT_W    = $clog2(TURN_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TURN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_q;
    logic             bus_oe_q;
    logic [WIDTH-1:0] bus_out_q;
    logic             rx_valid_q;
    logic [WIDTH-1:0] rx_data_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bus_oe_q   <= DIR_RX;
            bus_out_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            cnt_q      <= '0;
        end else begin
            rx_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (tx_valid) begin
                        state_q   <= ST_TX;
                        bus_oe_q  <= DIR_TX;
                        bus_out_q <= tx_data;
                    end else if (rx_req) begin
                        state_q <= ST_RX;
                    end
                end
                // rx_req is deliberately ignored while driving; the host must wait for IDLE.
                ST_TX: begin
                    if (tx_valid) begin
                        bus_out_q <= tx_data;
                    end else begin
                        state_q  <= ST_TURN;
                        bus_oe_q <= DIR_RX;
                    end
                end
                ST_RX: begin
                    if (rx_req) begin
                        rx_valid_q <= 1'b1;
                        rx_data_q  <= bus_in;
                    end else begin
                        state_q <= ST_TURN;
                    end
                end
                ST_TURN: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign tx_ready = (state_q == ST_IDLE) || (state_q == ST_TX);
    assign busy     = (state_q != ST_IDLE);
    assign bus_oe   = bus_oe_q;
    assign bus_out  = bus_out_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;

endmodule

// File: tb/tb_bidir_bus_ctrl.sv
// Directed bench for bidir_bus_ctrl with a peer driver model and a scoreboard
// for driven bus words and received samples; a second instance uses TURN_CYCLES=1.
module tb_bidir_bus_ctrl;

    logic       clk = 1'b0;
    logic       rst;

    logic       tx_valid, rx_req, tx_ready, rx_valid, bus_oe, busy;
    logic [7:0] tx_data, rx_data, bus_out, pin;
    logic       peer_drive;
    logic [7:0] peer_data;

    logic       t1_tx_valid, t1_rx_req, t1_tx_ready, t1_rx_valid, t1_bus_oe, t1_busy;
    logic [7:0] t1_tx_data, t1_rx_data, t1_bus_out, t1_bus_in;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];

    always #5 clk = ~clk;

    // Shared pin: our driver when bus_oe, otherwise the peer when it is asked to drive.
    always_comb begin
        pin = 8'h00;
        if (bus_oe)          pin = bus_out;
        else if (peer_drive) pin = peer_data;
    end

    bidir_bus_ctrl #(.WIDTH(8), .TURN_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_req(rx_req), .rx_valid(rx_valid), .rx_data(rx_data),
        .bus_oe(bus_oe), .bus_out(bus_out), .bus_in(pin), .busy(busy)
    );

    bidir_bus_ctrl #(.WIDTH(8), .TURN_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst),
        .tx_valid(t1_tx_valid), .tx_data(t1_tx_data), .tx_ready(t1_tx_ready),
        .rx_req(t1_rx_req), .rx_valid(t1_rx_valid), .rx_data(t1_rx_data),
        .bus_oe(t1_bus_oe), .bus_out(t1_bus_out), .bus_in(t1_bus_in), .busy(t1_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard and contention monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (peer_drive) chk("contention_oe_while_peer", {31'd0, bus_oe}, 32'd0);
            if (bus_oe) begin
                if (tx_q.size() == 0) chk("tx_unexpected_drive", {24'd0, bus_out}, 32'hFFFF_FFFF);
                else chk("tx_scoreboard", {24'd0, bus_out}, {24'd0, tx_q.pop_front()});
            end
            if (rx_valid) begin
                if (rx_q.size() == 0) chk("rx_unexpected_valid", {24'd0, rx_data}, 32'hFFFF_FFFF);
                else chk("rx_scoreboard", {24'd0, rx_data}, {24'd0, rx_q.pop_front()});
            end
        end
    end

    initial begin
        rst = 1'b1;
        tx_valid = 1'b0; tx_data = 8'h00; rx_req = 1'b0;
        peer_drive = 1'b0; peer_data = 8'h00;
        t1_tx_valid = 1'b0; t1_tx_data = 8'h00; t1_rx_req = 1'b0; t1_bus_in = 8'h00;
        step(); step();
        rst = 1'b0;
        #1;
        chk("reset_bus_oe",   {31'd0, bus_oe},   32'd0);
        chk("reset_busy",     {31'd0, busy},     32'd0);
        chk("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("reset_rx_data",  {24'd0, rx_data},  32'd0);
        chk("reset_bus_out",  {24'd0, bus_out},  32'd0);
        chk("reset_tx_ready", {31'd0, tx_ready}, 32'd1);

        // 1: async reset in the middle of a drive burst
        tx_valid = 1'b1; tx_data = 8'h77;
        step();
        chk("rst_pre_oe",  {31'd0, bus_oe},  32'd1);
        chk("rst_pre_out", {24'd0, bus_out}, 32'h77);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_oe",   {31'd0, bus_oe}, 32'd0);
        chk("rst_async_busy", {31'd0, busy},   32'd0);
        tx_valid = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        chk("rst_post_oe",       {31'd0, bus_oe},   32'd0);
        chk("rst_post_busy",     {31'd0, busy},     32'd0);
        chk("rst_post_rx_valid", {31'd0, rx_valid}, 32'd0);

        // 2: three-word burst, then two released TURN cycles
        tx_valid = 1'b1; tx_data = 8'hA1; tx_q.push_back(8'hA1);
        step();
        chk("tx_a1_oe",  {31'd0, bus_oe},  32'd1);
        chk("tx_a1_out", {24'd0, bus_out}, 32'hA1);
        tx_data = 8'hB2; tx_q.push_back(8'hB2);
        step();
        chk("tx_b2_out", {24'd0, bus_out}, 32'hB2);
        tx_data = 8'hC3; tx_q.push_back(8'hC3);
        step();
        chk("tx_c3_out", {24'd0, bus_out}, 32'hC3);
        chk("tx_c3_oe",  {31'd0, bus_oe},  32'd1);
        tx_valid = 1'b0;
        step();
        chk("turn1_oe",       {31'd0, bus_oe},   32'd0);
        chk("turn1_busy",     {31'd0, busy},     32'd1);
        chk("turn1_tx_ready", {31'd0, tx_ready}, 32'd0);
        step();
        chk("turn2_oe",   {31'd0, bus_oe}, 32'd0);
        chk("turn2_busy", {31'd0, busy},   32'd1);
        step();
        chk("tx_idle_busy",     {31'd0, busy},     32'd0);
        chk("tx_idle_tx_ready", {31'd0, tx_ready}, 32'd1);

        // 3: receive two words from the peer
        rx_req = 1'b1;
        step();
        chk("rx_enter_busy",     {31'd0, busy},     32'd1);
        chk("rx_enter_tx_ready", {31'd0, tx_ready}, 32'd0);
        peer_drive = 1'b1; peer_data = 8'h5A; rx_q.push_back(8'h5A);
        step();
        chk("rx_5a_valid", {31'd0, rx_valid}, 32'd1);
        chk("rx_5a_data",  {24'd0, rx_data},  32'h5A);
        peer_data = 8'h3C; rx_q.push_back(8'h3C);
        step();
        chk("rx_3c_valid", {31'd0, rx_valid}, 32'd1);
        chk("rx_3c_data",  {24'd0, rx_data},  32'h3C);
        rx_req = 1'b0; peer_drive = 1'b0; peer_data = 8'hEE;
        step();
        chk("rx_exit_valid", {31'd0, rx_valid}, 32'd0);
        chk("rx_exit_oe",    {31'd0, bus_oe},   32'd0);
        step(); step();
        chk("rx_idle_busy", {31'd0, busy}, 32'd0);

        // 4: rx_req falls as tx_valid rises
        rx_req = 1'b1;
        step();
        peer_drive = 1'b1; peer_data = 8'h11; rx_q.push_back(8'h11);
        step();
        rx_req = 1'b0; peer_drive = 1'b0;
        tx_valid = 1'b1; tx_data = 8'h9D; tx_q.push_back(8'h9D);
        step();
        chk("dir_turn1_oe", {31'd0, bus_oe}, 32'd0);
        step();
        chk("dir_turn2_oe", {31'd0, bus_oe}, 32'd0);
        step();
        chk("dir_idle_oe",   {31'd0, bus_oe}, 32'd0);
        chk("dir_idle_busy", {31'd0, busy},   32'd0);
        step();
        chk("dir_drive_oe",  {31'd0, bus_oe},  32'd1);
        chk("dir_drive_out", {24'd0, bus_out}, 32'h9D);
        tx_valid = 1'b0;
        step(); step(); step();
        chk("dir_end_busy", {31'd0, busy}, 32'd0);

        // 5: both requests in IDLE, TX wins and rx_req is ignored
        tx_valid = 1'b1; tx_data = 8'h42; tx_q.push_back(8'h42); rx_req = 1'b1;
        step();
        chk("prio_oe",  {31'd0, bus_oe},  32'd1);
        chk("prio_out", {24'd0, bus_out}, 32'h42);
        tx_valid = 1'b0;
        step();
        chk("prio_turn_oe",    {31'd0, bus_oe},   32'd0);
        chk("prio_rx_valid",   {31'd0, rx_valid}, 32'd0);
        rx_req = 1'b0;
        step(); step();
        chk("prio_idle_busy", {31'd0, busy}, 32'd0);

        // 6: TURN_CYCLES=1 instance, single released cycle
        t1_tx_valid = 1'b1; t1_tx_data = 8'hA1;
        step();
        chk("t1_a1_out", {24'd0, t1_bus_out}, 32'hA1);
        chk("t1_a1_oe",  {31'd0, t1_bus_oe},  32'd1);
        t1_tx_data = 8'hB2;
        step();
        chk("t1_b2_out", {24'd0, t1_bus_out}, 32'hB2);
        t1_tx_data = 8'hC3;
        step();
        chk("t1_c3_out", {24'd0, t1_bus_out}, 32'hC3);
        t1_tx_valid = 1'b0;
        step();
        chk("t1_turn_oe",   {31'd0, t1_bus_oe}, 32'd0);
        chk("t1_turn_busy", {31'd0, t1_busy},   32'd1);
        step();
        chk("t1_idle_busy",     {31'd0, t1_busy},     32'd0);
        chk("t1_idle_tx_ready", {31'd0, t1_tx_ready}, 32'd1);

        step();
        chk("tx_queue_drained", tx_q.size(), 32'd0);
        chk("rx_queue_drained", rx_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
